pwm3_table_reader: RTL and testbench

- Drives the shared 4-bit comparison-value ROM and consumes its three phase outputs, which are offset by +85 and +171 entries (120°/240°).
- Generates the table address from a phase accumulator.
- Latches the three 4-bit duty values once per carrier period and compares them against a center-aligned triangle carrier, producing the three-phase PWM outputs of the modulator.

---
 rtl/pwm3_table_reader.sv | 219 +++++++++++++++++++++
 tb/tb_pwm3_table_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm3_table_reader.sv
// pwm3_table_reader: three-phase table-driven PWM modulator.
// Walks a phase accumulator and drives the base address of a shared duty ROM.
// At each carrier boundary (cnt == 0) it latches the ROM's three phase outputs.
// Each latched duty is compared against a center-aligned triangle carrier.
// The compare result, registered, is the PWM output for that phase.
// Optional feature macro: PWM3_DEADTIME_EN adds complementary low-side outputs
// with DEAD clocks of dead-time on every edge of the raw compare.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | stopped; carrier parked at 0, outputs low
// RUN   | carrier running; at cnt == 0, duties latched and acc stepped
// DRAIN | en dropped; finish the current period, stop at the next cnt == 0
module pwm3_table_reader #(
    parameter int ACC_BITS = 24,
    parameter int CAR_MAX  = 15,
    parameter int DEAD     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] freq_word,
    input  logic [3:0]  rom_d1,
    input  logic [3:0]  rom_d2,
    input  logic [3:0]  rom_d3,
    output logic [15:0] rom_addr,
    output logic        rom_en,
    output logic        pwm_a,
    output logic        pwm_b,
    output logic        pwm_c,
`ifdef PWM3_DEADTIME_EN
    output logic        pwm_a_n,
    output logic        pwm_b_n,
    output logic        pwm_c_n,
`endif
    output logic        busy,
    output logic        sample_strobe
);

    localparam int CW = $clog2(CAR_MAX + 1);
    localparam int KW = (CW > 4) ? CW : 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                boundary;
    logic                latch_en;
    logic [CW-1:0]       cnt;
    logic                dir_dn;
    logic [ACC_BITS-1:0] acc;
    logic [ACC_BITS-1:0] acc_nx;
    logic [7:0]          addr_q;
    logic [3:0]          duty_a;
    logic [3:0]          duty_b;
    logic [3:0]          duty_c;
    logic                strobe_q;
    logic [2:0]          cmp_q;

    assign boundary = (state != IDLE) && (cnt == '0);
    assign acc_nx   = acc + ACC_BITS'(freq_word);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state. Stop/continue is decided only on boundary cycles.
    // Away from a boundary, RUN and DRAIN differ only in the en they saw last.
    always_comb begin
        state_nx = state;
        latch_en = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = RUN;
                end
            end
            RUN, DRAIN: begin
                if (boundary) begin
                    if (en) begin
                        state_nx = RUN;
                        latch_en = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    state_nx = en ? RUN : DRAIN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Triangle carrier: 0 up to CAR_MAX, then back down to 1, repeating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dir_dn <= 1'b0;
        end else if (state == IDLE || (boundary && !latch_en)) begin
            cnt    <= '0;
            dir_dn <= 1'b0;
        end else if (cnt == '0) begin
            cnt    <= CW'(1);
            dir_dn <= 1'b0;
        end else if (cnt == CW'(CAR_MAX)) begin
            cnt    <= CW'(CAR_MAX - 1);
            dir_dn <= 1'b1;
        end else if (dir_dn) begin
            cnt <= cnt - CW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Boundary update: latch duties from the current address, then step acc.
    // The ROM therefore sees a new address a full period before it is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            addr_q   <= '0;
            duty_a   <= '0;
            duty_b   <= '0;
            duty_c   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= latch_en;
            if (latch_en) begin
                duty_a <= rom_d1;
                duty_b <= rom_d2;
                duty_c <= rom_d3;
                acc    <= acc_nx;
                addr_q <= acc_nx[ACC_BITS-1 -: 8];
            end
        end
    end

    // Carrier compare, one clock behind cnt/duty; held low while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q <= '0;
        end else if (state == IDLE) begin
            cmp_q <= '0;
        end else begin
            cmp_q[0] <= KW'(cnt) < KW'(duty_a);
            cmp_q[1] <= KW'(cnt) < KW'(duty_b);
            cmp_q[2] <= KW'(cnt) < KW'(duty_c);
        end
    end

`ifdef PWM3_DEADTIME_EN
    localparam int            HW        = (DEAD < 2) ? 1 : $clog2(DEAD + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'((DEAD > 0) ? DEAD - 1 : 0);

    logic [2:0]    raw_q;
    logic [2:0]    hi_q;
    logic [2:0]    lo_q;
    logic [HW-1:0] hold_q [3];

    // Dead-time: any edge on the compare blanks both sides for DEAD clocks.
    // A pulse shorter than DEAD re-arms the blanking and never reaches an output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (state == IDLE) begin
                    raw_q[i]  <= 1'b0;
                    hi_q[i]   <= 1'b0;
                    lo_q[i]   <= 1'b0;
                    hold_q[i] <= '0;
                end else if (cmp_q[i] != raw_q[i]) begin
                    raw_q[i]  <= cmp_q[i];
                    hold_q[i] <= HOLD_LOAD;
                    hi_q[i]   <= 1'b0;
                    lo_q[i]   <= 1'b0;
                end else if (hold_q[i] != '0) begin
                    hold_q[i] <= hold_q[i] - HW'(1);
                    hi_q[i]   <= 1'b0;
                    lo_q[i]   <= 1'b0;
                end else begin
                    hi_q[i] <= raw_q[i];
                    lo_q[i] <= ~raw_q[i];
                end
            end
        end
    end

    assign pwm_a   = hi_q[0];
    assign pwm_b   = hi_q[1];
    assign pwm_c   = hi_q[2];
    assign pwm_a_n = lo_q[0];
    assign pwm_b_n = lo_q[1];
    assign pwm_c_n = lo_q[2];
`else
    assign pwm_a = cmp_q[0];
    assign pwm_b = cmp_q[1];
    assign pwm_c = cmp_q[2];
`endif

    assign rom_addr      = {8'h00, addr_q};
    assign rom_en        = (state != IDLE);
    assign busy          = (state != IDLE);
    assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_pwm3_table_reader.sv
// tb_pwm3_table_reader: directed bench for pwm3_table_reader (default build).
// A combinational ROM model feeds the DUT. Expected addresses come from a
// shadow accumulator. For cnt < d on the 0..15..1 triangle, duty d gives
// 2*d-1 high clocks per 30-clock period, or 0 clocks when d is 0.
module tb_pwm3_table_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] freq_word = 16'h0000;
    logic [3:0]  rom_d1;
    logic [3:0]  rom_d2;
    logic [3:0]  rom_d3;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic        pwm_a;
    logic        pwm_b;
    logic        pwm_c;
    logic        busy;
    logic        sample_strobe;

    logic [3:0]  tbl [256];
    logic [7:0]  a2;
    logic [7:0]  a3;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] m_acc = '0;
    logic [7:0]  m_lat = '0;
    logic [2:0]  v_first;
    logic [2:0]  v_peak;

    pwm3_table_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .freq_word     (freq_word),
        .rom_d1        (rom_d1),
        .rom_d2        (rom_d2),
        .rom_d3        (rom_d3),
        .rom_addr      (rom_addr),
        .rom_en        (rom_en),
        .pwm_a         (pwm_a),
        .pwm_b         (pwm_b),
        .pwm_c         (pwm_c),
        .busy          (busy),
        .sample_strobe (sample_strobe)
    );

    always #5 clk = ~clk;

    assign a2     = rom_addr[7:0] + 8'd85;
    assign a3     = rom_addr[7:0] + 8'd171;
    assign rom_d1 = tbl[rom_addr[7:0]];
    assign rom_d2 = tbl[a2];
    assign rom_d3 = tbl[a3];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int on_clocks(input logic [3:0] d);
        return (d == 4'd0) ? 0 : 2 * int'(d) - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a boundary edge that should have latched.
    task automatic strobe_update(input string tag);
        chk({tag, " strobe"}, int'(sample_strobe), 1);
        m_lat = m_acc[23:16];
        m_acc = m_acc + {8'h00, freq_word};
        chk({tag, " addr"}, int'(rom_addr), int'(m_acc[23:16]));
    endtask

    task automatic start_run(input logic [15:0] fw, input string tag);
        en        = 1'b1;
        freq_word = fw;
        tick();
        chk({tag, " busy_on"}, int'(busy), 1);
        chk({tag, " no_early_strobe"}, int'(sample_strobe), 0);
        tick();
        strobe_update(tag);
    endtask

    // One carrier period, starting right after a strobe sample.
    task automatic run_period(input string tag, input int drop_at, input int rise_at,
                              input bit stop);
        int         ca;
        int         cb;
        int         cc;
        int         early;
        int         idle_seen;
        logic [7:0] l2;
        logic [7:0] l3;
        ca = 0; cb = 0; cc = 0; early = 0; idle_seen = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            ca += int'(pwm_a);
            cb += int'(pwm_b);
            cc += int'(pwm_c);
            if (i == 1)  v_first = {pwm_a, pwm_b, pwm_c};
            if (i == 15) v_peak  = {pwm_a, pwm_b, pwm_c};
            if (i < 30) begin
                if (sample_strobe) early++;
                if (!busy) idle_seen++;
            end
            if (i == drop_at) en = 1'b0;
            if (i == rise_at) en = 1'b1;
        end
        l2 = m_lat + 8'd85;
        l3 = m_lat + 8'd171;
        chk({tag, " mid_strobes"}, early, 0);
        chk({tag, " mid_idle"}, idle_seen, 0);
        chk({tag, " hi_a"}, ca, on_clocks(tbl[m_lat]));
        chk({tag, " hi_b"}, cb, on_clocks(tbl[l2]));
        chk({tag, " hi_c"}, cc, on_clocks(tbl[l3]));
        if (stop) begin
            chk({tag, " last_strobe"}, int'(sample_strobe), 0);
            chk({tag, " busy_off"}, int'(busy), 0);
            chk({tag, " addr_hold"}, int'(rom_addr), int'(m_acc[23:16]));
            tick();
            chk({tag, " pwm_off"}, int'({pwm_a, pwm_b, pwm_c}), 0);
        end else begin
            strobe_update(tag);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbl[i] = 4'((i * 7) + 3);
        end
        tbl[0]   = 4'h8;
        tbl[85]  = 4'h3;
        tbl[171] = 4'hF;

        // Reset state.
        tick();
        tick();
        chk("rst rom_addr", int'(rom_addr), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst rom_en", int'(rom_en), 0);
        chk("rst strobe", int'(sample_strobe), 0);
        chk("rst pwm", int'({pwm_a, pwm_b, pwm_c}), 0);
        rst_n = 1'b1;
        tick();
        chk("idle holds", int'(busy), 0);

        // Duties 8/3/15 from entries 0/85/171; 0x0100 leaves the address at 0.
        start_run(16'h0100, "start");
        run_period("duty", 0, 0, 1'b0);
        chk("duty first_clock", int'(v_first), 3'b111);
        chk("duty carrier_peak", int'(v_peak), 3'b000);

        // freq_word = 0 freezes the address and re-latches every period.
        freq_word = 16'h0000;
        run_period("frozen", 0, 0, 1'b0);

        // en dropped for three clocks mid-period: no effect.
        run_period("toggle", 5, 8, 1'b0);

        // en dropped at cnt = 7 rising: drain to the boundary, then stop.
        run_period("stop", 6, 0, 1'b1);

        // Async reset mid-pulse at cnt = 5.
        start_run(16'hFFFF, "rs");
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst pwm_a", int'(pwm_a), 1);
        chk("pre_rst addr", int'(rom_addr), int'(m_acc[23:16]));
        #2 rst_n = 1'b0;
        #1;
        chk("async pwm", int'({pwm_a, pwm_b, pwm_c}), 0);
        chk("async rom_addr", int'(rom_addr), 0);
        chk("async busy", int'(busy), 0);
        chk("async rom_en", int'(rom_en), 0);
        m_acc = '0;
        tick();
        rst_n = 1'b1;

        // Restart, then step the address through 255 -> 0.
        start_run(16'hFFFF, "restart");
        chk("restart first_addr_used", int'(m_lat), 0);
        for (int k = 1; k <= 256; k++) begin
            run_period("wrap", 0, 0, 1'b0);
            if (k == 255) chk("wrap top_addr", int'(rom_addr), 255);
        end
        chk("wrap to_zero", int'(rom_addr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
